// File: rtl/memory_access_unit.sv
// Load/store unit bridging a single-request core port onto a word-wide bus.
// Optional macro MEMORY_ACCESS_UNIT_SPLIT_MISALIGNED_EN: split word-crossing misaligned accesses.
module memory_access_unit #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              request_valid,
  output logic              request_ready,
  input  logic              request_write,
  input  logic [2:0]        request_type,
  input  logic [XLEN-1:0]   request_address,
  input  logic [XLEN-1:0]   request_store_data,
  output logic              bus_valid,
  input  logic              bus_ready,
  output logic              bus_write,
  output logic [XLEN-1:0]   bus_address,
  output logic [XLEN-1:0]   bus_write_data,
  output logic [XLEN/8-1:0] bus_write_mask,
  input  logic [XLEN-1:0]   bus_read_data,
  input  logic              bus_error,
  output logic              response_valid,
  output logic [XLEN-1:0]   response_data,
  output logic              misaligned_exception,
  output logic              access_fault
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);
  localparam logic [31:0]     TO_LIMIT  = TIMEOUT_CYCLES;
  localparam logic [XLEN-1:0] WORD_STEP = NB;

`ifdef MEMORY_ACCESS_UNIT_SPLIT_MISALIGNED_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, FIRST, SECOND, RESPOND} state_t;

  function automatic logic illegal_type(input logic [2:0] t);
    return (t == 3'b111) || ((XLEN == 32) && (t == 3'b011 || t == 3'b110));
  endfunction

  function automatic logic [3:0] size_of(input logic [2:0] t);
    return 4'd1 << t[1:0];
  endfunction

  function automatic logic is_misaligned(input logic [XLEN-1:0] a, input logic [2:0] t);
    return ({{(4-OFFW){1'b0}}, a[OFFW-1:0]} & (size_of(t) - 4'd1)) != 4'd0;
  endfunction

  function automatic logic crosses_word(input logic [XLEN-1:0] a, input logic [2:0] t);
    return (5'(a[OFFW-1:0]) + 5'(size_of(t))) > 5'(NB);
  endfunction

  state_t            state, next_state;
  logic [XLEN-1:0]   addr_q, store_q, lo_q, hi_q;
  logic              write_q, fault_q, mis_q, cross_q;
  logic [2:0]        type_q;
  logic [31:0]       wait_cnt;
  logic              in_bus, timeout_hit, req_illegal, req_mis;

  assign in_bus      = (state == FIRST) || (state == SECOND);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && in_bus && !bus_ready && (wait_cnt == TO_LIMIT - 32'd1);
  assign req_illegal = illegal_type(request_type);
  assign req_mis     = is_misaligned(request_address, request_type);

  always_comb begin
    next_state = state;
    case (state)
      IDLE:
        if (request_valid) begin
          if (req_illegal || (req_mis && !SPLIT_EN)) next_state = RESPOND;
          else                                        next_state = FIRST;
        end
      FIRST:
        if (bus_ready) next_state = (cross_q && !bus_error) ? SECOND : RESPOND;
        else if (timeout_hit) next_state = RESPOND;
      SECOND:
        if (bus_ready || timeout_hit) next_state = RESPOND;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      addr_q   <= '0;
      store_q  <= '0;
      lo_q     <= '0;
      hi_q     <= '0;
      write_q  <= 1'b0;
      type_q   <= '0;
      fault_q  <= 1'b0;
      mis_q    <= 1'b0;
      cross_q  <= 1'b0;
      wait_cnt <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && request_valid) begin
        addr_q   <= request_address;
        store_q  <= request_store_data;
        write_q  <= request_write;
        type_q   <= request_type;
        lo_q     <= '0;
        hi_q     <= '0;
        wait_cnt <= '0;
        fault_q  <= req_illegal;
        mis_q    <= !req_illegal && req_mis && !SPLIT_EN;
        cross_q  <= SPLIT_EN && crosses_word(request_address, request_type);
      end else if (in_bus) begin
        if (bus_ready) begin
          wait_cnt <= '0;
          if (state == FIRST) lo_q <= bus_read_data;
          else                hi_q <= bus_read_data;
          if (bus_error) fault_q <= 1'b1;
        end else begin
          wait_cnt <= wait_cnt + 32'd1;
          if (timeout_hit) fault_q <= 1'b1;
        end
      end
    end
  end

  // Both bus words are treated as one double-width window shifted by the byte lane,
  // so aligned, in-word misaligned and split accesses share the same datapath.
  logic [OFFW-1:0]   off;
  logic [31:0]       size_bytes;
  logic [NB-1:0]     base_mask;
  logic [XLEN-1:0]   store_sized, raw, load_val;
  logic [2*NB-1:0]   wide_mask;
  logic [2*XLEN-1:0] wide_data, merged;
  logic              sign;

  always_comb begin
    off         = addr_q[OFFW-1:0];
    size_bytes  = 32'(size_of(type_q));
    base_mask   = '0;
    store_sized = '0;
    load_val    = '0;
    sign        = 1'b0;
    for (int unsigned i = 0; i < NB; i++) begin
      if (i < size_bytes) begin
        base_mask[i]        = 1'b1;
        store_sized[i*8+:8] = store_q[i*8+:8];
      end
    end
    wide_mask = {{NB{1'b0}}, base_mask} << off;
    wide_data = {{XLEN{1'b0}}, store_sized} << {off, 3'b000};
    merged    = {hi_q, lo_q} >> {off, 3'b000};
    raw       = merged[XLEN-1:0];
    case (type_q[1:0])
      2'd0:    sign = raw[7];
      2'd1:    sign = raw[15];
      2'd2:    sign = raw[31];
      default: sign = raw[XLEN-1];
    endcase
    sign = sign & ~type_q[2];
    for (int unsigned i = 0; i < NB; i++)
      load_val[i*8+:8] = base_mask[i] ? raw[i*8+:8] : {8{sign}};
  end

  assign request_ready  = (state == IDLE);
  assign bus_valid      = in_bus;
  assign bus_write      = in_bus && write_q;
  assign bus_address    = in_bus ? ({addr_q[XLEN-1:OFFW], {OFFW{1'b0}}} + ((state == SECOND) ? WORD_STEP : '0)) : '0;
  assign bus_write_data = (in_bus && write_q) ? ((state == SECOND) ? wide_data[2*XLEN-1:XLEN] : wide_data[XLEN-1:0]) : '0;
  assign bus_write_mask = (in_bus && write_q) ? ((state == SECOND) ? wide_mask[2*NB-1:NB] : wide_mask[NB-1:0]) : '0;

  assign response_valid       = (state == RESPOND);
  assign access_fault         = (state == RESPOND) && fault_q;
  assign misaligned_exception = (state == RESPOND) && mis_q;
  assign response_data        = ((state == RESPOND) && !write_q && !fault_q && !mis_q) ? load_val : '0;

endmodule

// File: tb/tb_memory_access_unit.sv
// Bench for memory_access_unit (XLEN=32, TIMEOUT_CYCLES=4): directed cases plus random traffic
// against a byte-array memory model; honours MEMORY_ACCESS_UNIT_SPLIT_MISALIGNED_EN.
module tb_memory_access_unit;

`ifdef MEMORY_ACCESS_UNIT_SPLIT_MISALIGNED_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        request_valid = 1'b0, request_ready, request_write = 1'b0;
  logic [2:0]  request_type = '0;
  logic [31:0] request_address = '0, request_store_data = '0;
  logic        bus_valid, bus_ready = 1'b0, bus_write, bus_error = 1'b0;
  logic [31:0] bus_address, bus_write_data, bus_read_data = '0;
  logic [3:0]  bus_write_mask;
  logic        response_valid, misaligned_exception, access_fault;
  logic [31:0] response_data;

  memory_access_unit #(.XLEN(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .request_valid(request_valid), .request_ready(request_ready),
    .request_write(request_write), .request_type(request_type),
    .request_address(request_address), .request_store_data(request_store_data),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_write(bus_write),
    .bus_address(bus_address), .bus_write_data(bus_write_data),
    .bus_write_mask(bus_write_mask), .bus_read_data(bus_read_data),
    .bus_error(bus_error), .response_valid(response_valid),
    .response_data(response_data), .misaligned_exception(misaligned_exception),
    .access_fault(access_fault)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] mem [256];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] ea);
    logic [31:0] w;
    for (int unsigned i = 0; i < 4; i++) w[i*8+:8] = mem[(ea + i) % 256];
    return w;
  endfunction

  function automatic logic [31:0] expected_load(input logic [31:0] a, input logic [2:0] ty);
    logic [63:0] v;
    int unsigned sz;
    sz = 1 << ty[1:0];
    v = '0;
    for (int unsigned i = 0; i < sz; i++) v = v | (64'(mem[(a + i) % 256]) << (8 * i));
    if (!ty[2] && v[8*sz-1]) v = v | (~64'd0 << (8 * sz));
    return v[31:0];
  endfunction

  // One complete request; the bench plays the bus slave, stalling each beat `stall` cycles.
  task automatic run(input bit wr, input logic [2:0] ty, input logic [31:0] a,
                     input logic [31:0] sd, input int unsigned stall, output logic [31:0] got);
    int unsigned sz, off, ntx;
    bit ill, mis, cr;
    logic [63:0] dwide, mwide, szmask;
    logic [31:0] ea, exp_val;
    sz  = 1 << ty[1:0];
    off = a % 4;
    ill = (ty == 3'd7) || (ty == 3'd3) || (ty == 3'd6);
    mis = (a % sz) != 0;
    cr  = (off + sz) > 4;
    szmask  = (64'd1 << (8 * sz)) - 64'd1;
    dwide   = (64'(sd) & szmask) << (8 * off);
    mwide   = ((64'd1 << sz) - 64'd1) << off;
    exp_val = expected_load(a, ty);
    got     = '0;

    request_valid = 1'b1; request_write = wr; request_type = ty;
    request_address = a; request_store_data = sd;
    check("request_ready_before_accept", request_ready, 1);
    tick();
    request_valid = 1'b0;
    request_address = $urandom; request_store_data = $urandom;
    request_type = 3'($urandom); request_write = 1'($urandom);

    if (ill || (mis && !SPLIT)) begin
      check("no_bus_on_reject", bus_valid, 0);
      check("reject_response_valid", response_valid, 1);
      check("reject_access_fault", access_fault, ill);
      check("reject_misaligned", misaligned_exception, !ill);
      check("reject_response_data", response_data, 0);
      got = response_data;
    end else begin
      ntx = cr ? 2 : 1;
      for (int unsigned k = 0; k < ntx; k++) begin
        ea = (a & ~32'd3) + 4 * k;
        for (int unsigned s = 0; s < stall; s++) begin
          check("bus_valid_stall", bus_valid, 1);
          check("bus_address_stall", bus_address, ea);
          tick();
        end
        bus_ready = 1'b1;
        bus_read_data = word_at(ea);
        check("bus_valid", bus_valid, 1);
        check("bus_address", bus_address, ea);
        check("bus_write", bus_write, wr);
        check("bus_write_mask", bus_write_mask, wr ? 4'((mwide >> (4 * k)) & 64'hF) : 4'h0);
        check("bus_write_data", bus_write_data, wr ? 32'(dwide >> (32 * k)) : 32'h0);
        check("no_early_response", response_valid, 0);
        tick();
        bus_ready = 1'b0;
        bus_read_data = $urandom;
      end
      check("bus_valid_dropped", bus_valid, 0);
      check("response_valid", response_valid, 1);
      check("response_fault", access_fault, 0);
      check("response_misaligned", misaligned_exception, 0);
      check("response_data", response_data, wr ? 32'h0 : exp_val);
      got = response_data;
      if (wr)
        for (int unsigned i = 0; i < sz; i++) mem[(a + i) % 256] = 8'(sd >> (8 * i));
    end
    tick();
    check("request_ready_after", request_ready, 1);
    check("response_one_cycle", response_valid, 0);
  endtask

  task automatic set_word(input int unsigned idx, input logic [31:0] w);
    for (int unsigned i = 0; i < 4; i++) mem[idx + i] = w[i*8+:8];
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] got;
    for (int unsigned i = 0; i < 256; i++) mem[i] = 8'($urandom);

    // Reset state
    tick(); tick();
    check("reset_request_ready", request_ready, 1);
    check("reset_bus_valid", bus_valid, 0);
    check("reset_response_valid", response_valid, 0);
    reset = 1'b0;
    check("idle_bus_address", bus_address, 0);
    check("idle_access_fault", access_fault, 0);
    check("idle_misaligned", misaligned_exception, 0);
    check("idle_response_data", response_data, 0);

    // Aligned word load, zero wait
    set_word(0, 32'h8000_1234);
    run(1'b0, 3'b010, 32'h100, 32'h0, 0, got);
    check("word_load_value", got, 32'h8000_1234);

    // Byte store to the top lane
    run(1'b1, 3'b000, 32'h103, 32'hAB, 0, got);

    // Signed / unsigned byte loads
    set_word(0, 32'h00F0_0000);
    run(1'b0, 3'b000, 32'h102, 32'h0, 1, got);
    check("lb_sign_ext", got, 32'hFFFF_FFF0);
    run(1'b0, 3'b100, 32'h102, 32'h0, 0, got);
    check("lbu_zero_ext", got, 32'h0000_00F0);

    // Misaligned word crossing into the next bus word
    set_word(0, 32'h5678_AAAA);
    set_word(4, 32'hBBBB_1234);
    run(1'b0, 3'b010, 32'h102, 32'h0, 0, got);
    check("split_word_load", got, SPLIT ? 32'h1234_5678 : 32'h0);

    // Illegal types
    run(1'b0, 3'b011, 32'h100, 32'h0, 0, got);
    run(1'b1, 3'b111, 32'h104, 32'h55, 0, got);

    // Timeout with bus_ready held low
    request_valid = 1'b1; request_write = 1'b0; request_type = 3'b010; request_address = 32'h100;
    tick();
    request_valid = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      check("timeout_bus_valid_held", bus_valid, 1);
      tick();
    end
    check("timeout_bus_valid_dropped", bus_valid, 0);
    check("timeout_response_valid", response_valid, 1);
    check("timeout_access_fault", access_fault, 1);
    check("timeout_response_data", response_data, 0);
    tick();
    check("timeout_back_idle", request_ready, 1);

    // Bus error
    request_valid = 1'b1; request_write = 1'b0; request_type = 3'b010; request_address = 32'h108;
    tick();
    request_valid = 1'b0;
    bus_ready = 1'b1; bus_error = 1'b1; bus_read_data = 32'hDEAD_BEEF;
    tick();
    bus_ready = 1'b0; bus_error = 1'b0;
    check("error_response_valid", response_valid, 1);
    check("error_access_fault", access_fault, 1);
    check("error_response_data", response_data, 0);
    tick();

    // Reset during an outstanding bus transaction
    request_valid = 1'b1; request_write = 1'b1; request_type = 3'b010;
    request_address = 32'h10C; request_store_data = 32'h1111_2222;
    tick();
    request_valid = 1'b0;
    check("pre_reset_bus_valid", bus_valid, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("reset_drops_bus_valid", bus_valid, 0);
    check("reset_no_response", response_valid, 0);
    check("reset_request_ready_again", request_ready, 1);
    tick();
    check("reset_still_no_response", response_valid, 0);

    // Random traffic
    for (int unsigned n = 0; n < 80; n++) begin
      run(1'($urandom), 3'($urandom_range(0, 7)), 32'h100 + $urandom_range(0, 255),
          $urandom, $urandom_range(0, 3), got);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
